// File: rtl/xy_waypoint_seq.sv
// ---------------------------------------------------------------------------
// xy_waypoint_seq
//   Stores up to DEPTH BCD X/Y waypoints and plays them out to a positioner.
//   Each waypoint is presented on target, a motion request of MOTION_PULSE
//   cycles is issued, then the block waits until the positioner feedback has
//   matched the target for SETTLE consecutive cycles.  If that does not happen
//   within TIMEOUT cycles the sequence aborts with fault set.
//
//   Optional build macro: XY_WAYPOINT_SEQ_LOOP_EN
//     defined   -> after the last waypoint, done pulses and playback wraps to
//                  waypoint 0 until halt or fault.
//     undefined -> single pass, ends in DONE then IDLE.
//
// Ports
//   clk        in   single clock
//   reset      in   asynchronous, active-high reset
//   wr_en      in   append load_data to the buffer (IDLE only)
//   load_data  in   [7:0] waypoint, X in 7:4, Y in 3:0, BCD
//   clear      in   empty the buffer (IDLE only)
//   start      in   begin playback (IDLE, wp_count > 0)
//   halt       in   abort playback
//   x_pos      in   [3:0] positioner X feedback
//   y_pos      in   [3:0] positioner Y feedback
//   target     out  [7:0] current waypoint to positioner
//   motion     out  motion request
//   busy       out  sequence active
//   done       out  one-cycle completion pulse
//   fault      out  sticky: timeout, overflow or non-BCD write
//   wp_index   out  [3:0] waypoint being executed
//   wp_count   out  [4:0] number of stored waypoints
//
// State      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | accept writes/clear/start; outputs held
// PRESENT    | target shows buffer[wp_index] for one cycle
// PULSE      | motion high for MOTION_PULSE cycles
// WAIT       | wait for SETTLE on-target cycles, bounded by TIMEOUT
// ADVANCE    | step to next waypoint or finish
// DONE       | done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module xy_waypoint_seq #(
    parameter int DEPTH        = 8,
    parameter int MOTION_PULSE = 2,
    parameter int SETTLE       = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] load_data,
    input  logic       clear,
    input  logic       start,
    input  logic       halt,
    input  logic [3:0] x_pos,
    input  logic [3:0] y_pos,
    output logic [7:0] target,
    output logic       motion,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] wp_index,
    output logic [4:0] wp_count
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C   = 5'(DEPTH);
    localparam logic [3:0]  PULSE_LD  = 4'(MOTION_PULSE - 1);
    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [15:0] TMO_LD    = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESENT = 3'd1,
        PULSE   = 3'd2,
        WAIT    = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  target_q, target_nxt;
    logic [3:0]  index_q, index_nxt;
    logic [4:0]  count_q, count_nxt;
    logic        fault_q, fault_nxt;
    logic [3:0]  pulse_cnt, pulse_nxt;
    logic [3:0]  settle_cnt, settle_nxt;
    logic [15:0] tmo_cnt, tmo_nxt;
    logic        mem_we;

    // Buffer is deliberately not reset; entries are only read below wp_count.
    logic [7:0]  mem [DEPTH];

    logic        bad_bcd;
    logic        on_target;
    logic        last_wp;
    logic [3:0]  index_inc;

    assign bad_bcd   = (load_data[7:4] > 4'd9) || (load_data[3:0] > 4'd9);
    assign on_target = (x_pos == target_q[7:4]) && (y_pos == target_q[3:0]);
    assign last_wp   = ({1'b0, index_q} == (count_q - 5'd1));
    assign index_inc = index_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target_q   <= '0;
            index_q    <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            pulse_cnt  <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            target_q   <= target_nxt;
            index_q    <= index_nxt;
            count_q    <= count_nxt;
            fault_q    <= fault_nxt;
            pulse_cnt  <= pulse_nxt;
            settle_cnt <= settle_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= load_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target_q;
        index_nxt  = index_q;
        count_nxt  = count_q;
        fault_nxt  = fault_q;
        pulse_nxt  = pulse_cnt;
        settle_nxt = settle_cnt;
        tmo_nxt    = tmo_cnt;
        mem_we     = 1'b0;

        case (state)
            IDLE: begin
                // clear beats wr_en, and wr_en beats start
                if (clear) begin
                    count_nxt = '0;
                end else if (wr_en) begin
                    if ((count_q == DEPTH_C) || bad_bcd) begin
                        fault_nxt = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        count_nxt = count_q + 5'd1;
                    end
                end else if (start && (count_q != 5'd0)) begin
                    state_nxt  = PRESENT;
                    index_nxt  = '0;
                    fault_nxt  = 1'b0;
                    target_nxt = mem[0];
                end
            end

            PRESENT: begin
                state_nxt = PULSE;
                pulse_nxt = PULSE_LD;
            end

            PULSE: begin
                if (pulse_cnt == 4'd0) begin
                    state_nxt  = WAIT;
                    settle_nxt = SETTLE_LD;
                    tmo_nxt    = TMO_LD;
                end else begin
                    pulse_nxt = pulse_cnt - 4'd1;
                end
            end

            WAIT: begin
                // arrival in the final allowed cycle still counts
                if (on_target && (settle_cnt == 4'd0)) begin
                    state_nxt = ADVANCE;
                end else begin
                    settle_nxt = on_target ? (settle_cnt - 4'd1) : SETTLE_LD;
                    if (tmo_cnt == 16'd0) begin
                        fault_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tmo_nxt = tmo_cnt - 16'd1;
                    end
                end
            end

            ADVANCE: begin
                if (last_wp) begin
`ifdef XY_WAYPOINT_SEQ_LOOP_EN
                    index_nxt  = '0;
                    target_nxt = mem[0];
                    state_nxt  = PRESENT;
`else
                    state_nxt  = DONE;
`endif
                end else begin
                    index_nxt  = index_inc;
                    target_nxt = mem[index_inc[AW-1:0]];
                    state_nxt  = PRESENT;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // halt wins over arrival and timeout; nothing else changes
        if (halt && (state != IDLE)) begin
            state_nxt  = IDLE;
            fault_nxt  = fault_q;
            target_nxt = target_q;
            index_nxt  = index_q;
        end
    end

    assign target   = target_q;
    assign wp_index = index_q;
    assign wp_count = count_q;
    assign fault    = fault_q;
    assign motion   = (state == PULSE);
    assign busy     = (state != IDLE);
`ifdef XY_WAYPOINT_SEQ_LOOP_EN
    assign done     = (state == DONE) || ((state == ADVANCE) && last_wp);
`else
    assign done     = (state == DONE);
`endif

endmodule

// File: tb/tb_xy_waypoint_seq.sv
module tb_xy_waypoint_seq;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] load_data;
    logic       clear;
    logic       start;
    logic       halt;
    logic [3:0] x_pos;
    logic [3:0] y_pos;
    logic [7:0] target;
    logic       motion;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] wp_index;
    logic [4:0] wp_count;

    int n_total = 0;
    int n_pass  = 0;

    // positioner model: 0 converge 6 cycles after motion, 1 never arrive, 2 manual
    int         pos_mode = 0;
    logic [3:0] man_x = 4'hF;
    logic [3:0] man_y = 4'hF;
    logic [3:0] conv_x = 4'hF;
    logic [3:0] conv_y = 4'hF;
    int         conv_ctr = 0;
    logic       pos_motion_prev = 1'b0;

    logic [7:0] tq[$];
    logic [3:0] dq[$];
    logic       mon_motion_prev = 1'b0;
    int         pulse_len = 0;

    assign x_pos = (pos_mode == 2) ? man_x : ((pos_mode == 1) ? 4'hF : conv_x);
    assign y_pos = (pos_mode == 2) ? man_y : ((pos_mode == 1) ? 4'hF : conv_y);

    xy_waypoint_seq #(
        .DEPTH(8), .MOTION_PULSE(2), .SETTLE(4), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .load_data(load_data),
        .clear(clear), .start(start), .halt(halt), .x_pos(x_pos), .y_pos(y_pos),
        .target(target), .motion(motion), .busy(busy), .done(done), .fault(fault),
        .wp_index(wp_index), .wp_count(wp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (pos_mode == 0) begin
            if (motion && !pos_motion_prev) begin
                conv_x   = 4'hF;
                conv_y   = 4'hF;
                conv_ctr = 6;
            end else if (conv_ctr > 0) begin
                conv_ctr--;
                if (conv_ctr == 0) begin
                    conv_x = target[7:4];
                    conv_y = target[3:0];
                end
            end
        end
        pos_motion_prev = motion;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (motion && !mon_motion_prev) begin
                pulse_len = 1;
                if (tq.size() == 0) chk("unexpected_motion", 1, 0);
                else chk("target_at_motion", target, tq.pop_front());
            end else if (motion) begin
                pulse_len++;
            end
            if (!motion && mon_motion_prev && busy) chk("motion_pulse_len", pulse_len, 2);
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_wp_index", wp_index, dq.pop_front());
            end
        end
        mon_motion_prev = motion;
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk); wr_en = 1'b1; load_data = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound && ok == 0; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        reset = 1'b1; wr_en = 1'b0; load_data = '0; clear = 1'b0;
        start = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_target", target, 0);
        chk("rst_motion", motion, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_wp_index", wp_index, 0);
        chk("rst_wp_count", wp_count, 0);
        reset = 1'b0;

        // basic two-waypoint run
        wr(8'h35); wr(8'h72);
        chk("load2_count", wp_count, 2);
        chk("load2_fault", fault, 0);
        tq.push_back(8'h35); tq.push_back(8'h72); dq.push_back(4'd1);
        do_start();
        chk("start_busy", busy, 1);
        chk("start_index", wp_index, 0);
        chk("present_target", target, 8'h35);
        wait_idle("run1_finish", 200);
        chk("run1_done_low", done, 0);
        chk("run1_index", wp_index, 1);
        chk("run1_target_held", target, 8'h72);

        // replay
        tq.push_back(8'h35); tq.push_back(8'h72); dq.push_back(4'd1);
        do_start();
        wait_idle("replay_finish", 200);
        chk("replay_index", wp_index, 1);

        // overflow: ninth entry dropped
        do_clear();
        chk("clear_count", wp_count, 0);
        for (int i = 0; i < 9; i++) wr(8'(i * 17));
        chk("ovf_count", wp_count, 8);
        chk("ovf_fault", fault, 1);
        for (int i = 0; i < 8; i++) tq.push_back(8'(i * 17));
        dq.push_back(4'd7);
        do_start();
        chk("start_clears_fault", fault, 0);
        wait_idle("run8_finish", 600);
        chk("run8_index", wp_index, 7);

        // clear beats write; non-BCD writes
        @(negedge clk); clear = 1'b1; wr_en = 1'b1; load_data = 8'h12;
        @(negedge clk); clear = 1'b0; wr_en = 1'b0;
        chk("clr_wr_count", wp_count, 0);
        chk("clr_wr_fault", fault, 0);
        wr(8'hA3);
        chk("badx_count", wp_count, 0);
        chk("badx_fault", fault, 1);
        wr(8'h4A);
        chk("bady_count", wp_count, 0);
        do_start();
        chk("empty_start_busy", busy, 0);
        chk("empty_start_fault", fault, 1);

        // write beats start
        @(negedge clk); wr_en = 1'b1; start = 1'b1; load_data = 8'h12;
        @(negedge clk); wr_en = 1'b0; start = 1'b0;
        chk("wr_start_count", wp_count, 1);
        chk("wr_start_busy", busy, 0);

        // settle glitch: 3 on, 1 off, 4 on
        pos_mode = 2; man_x = 4'hF; man_y = 4'hF;
        tq.push_back(8'h12); dq.push_back(4'd0);
        do_start();
        chk("settle_start_fault", fault, 0);
        repeat (3) @(negedge clk);
        man_x = 4'h1; man_y = 4'h2;
        repeat (3) @(negedge clk);
        man_y = 4'h3;
        @(negedge clk);
        man_y = 4'h2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) chk("settle_busy_mid", busy, 1);
            if (i >= 2) chk("settle_no_early_done", done, 0);
        end
        @(negedge clk);
        chk("settle_done", done, 1);
        wait_idle("settle_finish", 20);

        // timeout after 20 WAIT cycles
        pos_mode = 1;
        tq.push_back(8'h12);
        do_start();
        repeat (22) @(negedge clk);
        chk("tmo_busy_before", busy, 1);
        chk("tmo_fault_before", fault, 0);
        @(negedge clk);
        chk("tmo_fault", fault, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_motion", motion, 0);
        chk("tmo_target_held", target, 8'h12);
        pos_mode = 0;
        tq.push_back(8'h12); dq.push_back(4'd0);
        do_start();
        chk("tmo_restart_fault", fault, 0);
        wait_idle("tmo_restart_finish", 200);

        // halt during PULSE of waypoint 1
        do_clear(); wr(8'h35); wr(8'h72);
        tq.push_back(8'h35); tq.push_back(8'h72);
        do_start();
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            @(negedge clk);
            if (motion && wp_index == 4'd1) ok = 1;
        end
        chk("halt_reach_pulse", ok, 1);
        halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        chk("halt_motion", motion, 0);
        chk("halt_busy", busy, 0);
        chk("halt_done", done, 0);
        chk("halt_target", target, 8'h72);
        repeat (3) @(negedge clk);

`ifdef XY_WAYPOINT_SEQ_LOOP_EN
        for (int i = 0; i < 2; i++) begin
            tq.push_back(8'h35); tq.push_back(8'h72); dq.push_back(4'd1);
        end
        do_start();
        ok = 0;
        for (int i = 0; i < 400 && ok < 2; i++) begin
            @(negedge clk);
            if (done) ok++;
        end
        chk("loop_two_dones", ok, 2);
        halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        chk("loop_halt_busy", busy, 0);
        repeat (3) @(negedge clk);
`endif

        // async reset in WAIT
        pos_mode = 1;
        tq.push_back(8'h35);
        do_start();
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_target", target, 0);
        chk("areset_busy", busy, 0);
        chk("areset_motion", motion, 0);
        chk("areset_done", done, 0);
        chk("areset_fault", fault, 0);
        chk("areset_index", wp_index, 0);
        chk("areset_count", wp_count, 0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        chk("target_queue_empty", tq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
